// File: rtl/mem_pkg.sv
// Shared types and constants for the matching-pairs game controller.
package mem_pkg;

   localparam int CARD_W  = 4;
   localparam int SCORE_W = 4;

   typedef enum logic [2:0] {
      PICK1   = 3'd0,
      PICK2   = 3'd1,
      COMPARE = 3'd2,
      SHOW    = 3'd3,
      CHECK   = 3'd4,
      SWITCH  = 3'd5,
      DONE    = 3'd6
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P0   = 2'b01;
   localparam logic [1:0] WIN_P1   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   function automatic logic [1:0] winner_of(input logic [SCORE_W-1:0] s0,
                                            input logic [SCORE_W-1:0] s1);
      if (s0 > s1) return WIN_P0;
      if (s1 > s0) return WIN_P1;
      return WIN_TIE;
   endfunction

endpackage

// File: rtl/mem_tick_timer.sv
// Loadable down-counter stepped by the timebase strobe; holds at zero.
module mem_tick_timer #(
   parameter int           W       = 5,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_i,
   input  logic         en_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] value_o,
   output logic         zero_o
);

   logic [W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load_i)
         value_d = load_val_i;
      else if (en_i && tick_i && (value_q != '0))
         value_d = value_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) value_q <= RST_VAL;
      else      value_q <= value_d;
   end

   assign value_o = value_q;
   assign zero_o  = (value_q == '0);

endmodule

// File: rtl/mem_game_ctrl.sv
// Two-player matching-pairs sequencer: cursor, masks, turn timer, scores, winner.
// Define MEMCTRL_KEEP_TURN_EN to let a player who finds a pair keep the turn.
module mem_game_ctrl
   import mem_pkg::*;
#(
   parameter int N_CARDS    = 16,
   parameter int TURN_TICKS = 15,
   parameter int SHOW_TICKS = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_i,
   input  logic               btn_next_i,
   input  logic               btn_sel_i,
   input  logic [CARD_W-1:0]  card_val_i,
   output logic [3:0]         card_idx_o,
   output logic [3:0]         cursor_o,
   output logic [N_CARDS-1:0] revealed_o,
   output logic [N_CARDS-1:0] matched_o,
   output logic               player_o,
   output logic [SCORE_W-1:0] score0_o,
   output logic [SCORE_W-1:0] score1_o,
   output logic [4:0]         time_left_o,
   output logic [2:0]         state_o,
   output logic               game_over_o,
   output logic [1:0]         winner_o
);

`ifdef MEMCTRL_KEEP_TURN_EN
   localparam bit KEEP_TURN = 1'b1;
`else
   localparam bit KEEP_TURN = 1'b0;
`endif

   state_t               state_q, state_d;
   logic [3:0]           cursor_q, cursor_d;
   logic [N_CARDS-1:0]   revealed_q, revealed_d;
   logic [N_CARDS-1:0]   matched_q, matched_d;
   logic                 player_q, player_d;
   logic [SCORE_W-1:0]   score0_q, score0_d, score1_q, score1_d;
   logic [3:0]           idx1_q, idx1_d, idx2_q, idx2_d;
   logic [CARD_W-1:0]    val1_q, val1_d, val2_q, val2_d;
   logic                 game_over_q, game_over_d;
   logic [1:0]           winner_q, winner_d;

   logic       in_pick, timeout, sel_ok, all_matched, vals_equal;
   logic       turn_zero, turn_load, show_zero;
   logic [4:0] turn_value, show_value;

   assign in_pick     = (state_q == PICK1) || (state_q == PICK2);
   assign timeout     = in_pick && turn_zero;
   // Matched cards stay revealed, so one test covers both "revealed" and "matched".
   assign sel_ok      = in_pick && btn_sel_i && !timeout && !revealed_q[cursor_q];
   assign all_matched = &matched_q;
   assign vals_equal  = (val1_q == val2_q);
   assign turn_load   = (state_q == SWITCH) ||
                        ((state_q == CHECK) && !all_matched && KEEP_TURN);

   mem_tick_timer #(.W(5), .RST_VAL(5'(TURN_TICKS))) u_turn_timer (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick_i),
      .en_i       (in_pick),
      .load_i     (turn_load),
      .load_val_i (5'(TURN_TICKS)),
      .value_o    (turn_value),
      .zero_o     (turn_zero)
   );

   mem_tick_timer #(.W(5), .RST_VAL(5'd0)) u_show_timer (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick_i),
      .en_i       (state_q == SHOW),
      .load_i     (state_q == COMPARE),
      .load_val_i (5'(SHOW_TICKS)),
      .value_o    (show_value),
      .zero_o     (show_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= PICK1;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PICK1:   if (timeout) state_d = SWITCH; else if (sel_ok) state_d = PICK2;
         PICK2:   if (timeout) state_d = SWITCH; else if (sel_ok) state_d = COMPARE;
         COMPARE: state_d = vals_equal ? CHECK : SHOW;
         SHOW:    if (show_zero) state_d = SWITCH;
         CHECK:   if (all_matched)    state_d = DONE;
                  else if (KEEP_TURN) state_d = PICK1;
                  else                state_d = SWITCH;
         SWITCH:  state_d = PICK1;
         DONE:    state_d = DONE;
         default: state_d = PICK1;
      endcase
   end

   always_comb begin
      cursor_d    = cursor_q;
      revealed_d  = revealed_q;
      matched_d   = matched_q;
      player_d    = player_q;
      score0_d    = score0_q;
      score1_d    = score1_q;
      idx1_d      = idx1_q;
      idx2_d      = idx2_q;
      val1_d      = val1_q;
      val2_d      = val2_q;
      game_over_d = game_over_q;
      winner_d    = winner_q;

      if (in_pick && btn_next_i && !btn_sel_i)
         cursor_d = (cursor_q == 4'(N_CARDS - 1)) ? 4'd0 : cursor_q + 4'd1;

      case (state_q)
         PICK1: if (sel_ok) begin
            idx1_d               = cursor_q;
            val1_d               = card_val_i;
            revealed_d[cursor_q] = 1'b1;
         end
         PICK2: if (timeout) begin
            revealed_d[idx1_q] = 1'b0;
         end else if (sel_ok) begin
            idx2_d               = cursor_q;
            val2_d               = card_val_i;
            revealed_d[cursor_q] = 1'b1;
         end
         COMPARE: if (vals_equal) begin
            matched_d[idx1_q] = 1'b1;
            matched_d[idx2_q] = 1'b1;
            if (player_q) score1_d = score1_q + 1'b1;
            else          score0_d = score0_q + 1'b1;
         end
         SHOW: if (show_zero) begin
            revealed_d[idx1_q] = 1'b0;
            revealed_d[idx2_q] = 1'b0;
         end
         CHECK: if (all_matched) begin
            game_over_d = 1'b1;
            winner_d    = winner_of(score0_q, score1_q);
         end
         SWITCH:  player_d = ~player_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cursor_q    <= '0;
         revealed_q  <= '0;
         matched_q   <= '0;
         player_q    <= 1'b0;
         score0_q    <= '0;
         score1_q    <= '0;
         idx1_q      <= '0;
         idx2_q      <= '0;
         val1_q      <= '0;
         val2_q      <= '0;
         game_over_q <= 1'b0;
         winner_q    <= WIN_NONE;
      end else begin
         cursor_q    <= cursor_d;
         revealed_q  <= revealed_d;
         matched_q   <= matched_d;
         player_q    <= player_d;
         score0_q    <= score0_d;
         score1_q    <= score1_d;
         idx1_q      <= idx1_d;
         idx2_q      <= idx2_d;
         val1_q      <= val1_d;
         val2_q      <= val2_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
      end
   end

   assign card_idx_o  = cursor_q;
   assign cursor_o    = cursor_q;
   assign revealed_o  = revealed_q;
   assign matched_o   = matched_q;
   assign player_o    = player_q;
   assign score0_o    = score0_q;
   assign score1_o    = score1_q;
   assign time_left_o = turn_value;
   assign state_o     = state_q;
   assign game_over_o = game_over_q;
   assign winner_o    = winner_q;

endmodule
